// File: rtl/mem_readback_pkg.sv
// mem_readback_pkg: shared types for the memory dump engine
// Contents: state_t, the five-state dump FSM encoding
package mem_readback_pkg;
    typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;
endpackage

// File: rtl/mem_readback_if.sv
// mem_readback_if: memory read port plus dump stream bundle
// Ports: mem_rd/mem_addr/mem_data (memory side), dump_valid/dump_ready/dump_data/dump_addr/dump_last (stream side)
// master: the dump engine; slave: the memory and downstream consumer
interface mem_readback_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
);
    logic                  mem_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  dump_valid;
    logic                  dump_ready;
    logic [DATA_WIDTH-1:0] dump_data;
    logic [ADDR_WIDTH-1:0] dump_addr;
    logic                  dump_last;
    modport master (
        output mem_rd, mem_addr, dump_valid, dump_data, dump_addr, dump_last,
        input  mem_data, dump_ready
    );
    modport slave (
        input  mem_rd, mem_addr, dump_valid, dump_data, dump_addr, dump_last,
        output mem_data, dump_ready
    );
endinterface

// File: rtl/mem_readback.sv
// mem_readback: dumps every memory location over a valid/ready stream with a running XOR checksum
// Ports: clk, rst (async, active high), start (dump request, sampled in IDLE),
//        bus (mem_readback_if.master: memory read port and dump stream),
//        busy (not IDLE), done (one-cycle end pulse), checksum (XOR of dumped bytes)
module mem_readback
    import mem_readback_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    mem_readback_if.master        bus,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum
);
    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = '1;
    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  hs;
    assign hs             = state == SEND && bus.dump_ready;
    assign bus.mem_rd     = state == READ;
    assign bus.mem_addr   = cnt;
    assign bus.dump_valid = state == SEND;
    assign bus.dump_last  = state == SEND && bus.dump_addr == MAX_ADDR;
    assign busy           = state != IDLE;
    assign done           = state == DONE;
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start ? READ : IDLE;
            READ:    next_state = WAIT;
            WAIT:    next_state = SEND;
            SEND:    next_state = hs ? (cnt == MAX_ADDR ? DONE : READ) : SEND;
            default: next_state = IDLE;
        endcase
    end
    // counter stops at MAX_ADDR so the final dump_addr/mem_addr stay on the last location
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.dump_data <= '0;
            bus.dump_addr <= '0;
            checksum      <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && start) begin
                cnt      <= '0;
                checksum <= '0;
            end
            if (state == WAIT) begin
                bus.dump_data <= bus.mem_data;
                bus.dump_addr <= cnt;
                checksum      <= checksum ^ bus.mem_data;
            end
            if (hs && cnt != MAX_ADDR)
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_readback.sv
// tb_mem_readback: scoreboard bench for mem_readback with a registered memory model
module tb_mem_readback;
    logic       clk;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] checksum;
    mem_readback_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) bus ();
    mem_readback #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );
    typedef struct packed {
        logic [4:0] a;
        logic [7:0] d;
        logic       l;
    } exp_t;
    logic [7:0] mem [32];
    exp_t       q [$];
    int         vectors = 0;
    int         errors = 0;
    int         n_bytes, n_done, done_cycle;
    int         rd_count [32];
    logic [7:0] exp_checksum;
    initial clk = 0;
    always #5 clk = ~clk;
    // memory answers one cycle after mem_rd
    always @(posedge clk) if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
    task automatic load_base();
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[0] = 8'hBC; mem[1] = 8'hDA; mem[26] = 8'h05; mem[28] = 8'h05;
    endtask
    // mode 0: ready always high; 1: ready low 10 cycles at address 1; 2: random ready
    task automatic run_dump(input int mode, input int restart_at, input int reset_at);
        exp_t       e;
        logic       held = 0;
        logic [4:0] h_addr = 0;
        logic [7:0] h_data = 0;
        logic       r;
        int         stall = 0;
        int         cyc = 0;
        bit         restarted = 0;
        bit         finished = 0;
        bit         aborted = 0;
        q.delete();
        exp_checksum = 8'h00;
        for (int i = 0; i < 32; i++) begin
            e.a = 5'(i); e.d = mem[i]; e.l = (i == 31);
            q.push_back(e);
            exp_checksum ^= mem[i];
        end
        n_bytes = 0; n_done = 0; done_cycle = -1;
        for (int i = 0; i < 32; i++) rd_count[i] = 0;
        @(negedge clk);
        start = 1; bus.dump_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        while (cyc < 3000) begin
            start = 0;
            if (done) begin
                n_done++;
                if (done_cycle < 0) done_cycle = cyc;
            end
            if (bus.mem_rd) rd_count[bus.mem_addr]++;
            vectors++;
            if (bus.dump_last !== (bus.dump_valid && bus.dump_addr == 5'h1F)) begin
                errors++;
                $display("FAIL last_flag cyc=%0d last=%b valid=%b addr=%h", cyc, bus.dump_last, bus.dump_valid, bus.dump_addr);
            end
            if (held) begin
                vectors++;
                if (bus.dump_valid !== 1'b1 || bus.dump_addr !== h_addr || bus.dump_data !== h_data) begin
                    errors++;
                    $display("FAIL stall_hold cyc=%0d got v=%b a=%h d=%h want v=1 a=%h d=%h", cyc, bus.dump_valid, bus.dump_addr, bus.dump_data, h_addr, h_data);
                end
            end
            if (reset_at >= 0 && bus.dump_valid && bus.dump_addr == 5'(reset_at)) begin
                rst = 1;
                @(posedge clk);
                #1;
                aborted = 1;
                break;
            end
            if (restart_at >= 0 && !restarted && bus.dump_valid && bus.dump_addr == 5'(restart_at)) begin
                start = 1;
                restarted = 1;
            end
            if (mode == 0) r = 1'b1;
            else if (mode == 1) begin
                if (bus.dump_valid && bus.dump_addr == 5'h01 && stall < 10) begin r = 1'b0; stall++; end
                else r = 1'b1;
            end else r = 1'($urandom_range(0, 1));
            bus.dump_ready = r;
            held = 0;
            if (bus.dump_valid) begin
                if (r) begin
                    vectors++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_byte got a=%h d=%h want none", bus.dump_addr, bus.dump_data);
                    end else begin
                        e = q.pop_front();
                        if ({bus.dump_addr, bus.dump_data, bus.dump_last} !== {e.a, e.d, e.l}) begin
                            errors++;
                            $display("FAIL byte got a=%h d=%h l=%b want a=%h d=%h l=%b", bus.dump_addr, bus.dump_data, bus.dump_last, e.a, e.d, e.l);
                        end
                    end
                    n_bytes++;
                end else begin
                    held = 1; h_addr = bus.dump_addr; h_data = bus.dump_data;
                end
            end
            if (n_done > 0 && !busy) begin
                finished = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (!finished && !aborted) begin
            errors++;
            $display("FAIL timeout got no completion after %0d cycles want done", cyc);
        end
        start = 0;
        bus.dump_ready = 1'b0;
    endtask
    task automatic test_reset();
        rst = 1; start = 0; bus.dump_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, bus.dump_valid, bus.dump_last, bus.mem_rd} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000", {busy, done, bus.dump_valid, bus.dump_last, bus.mem_rd});
        end
        vectors++;
        if ({bus.mem_addr, bus.dump_addr, bus.dump_data, checksum} !== 26'b0) begin
            errors++;
            $display("FAIL reset_data got ma=%h da=%h dd=%h ck=%h want 0", bus.mem_addr, bus.dump_addr, bus.dump_data, checksum);
        end
        @(negedge clk);
        rst = 0;
    endtask
    task automatic test_full_dump();
        load_base();
        run_dump(0, -1, -1);
        vectors++;
        if (n_bytes !== 32 || n_done !== 1) begin
            errors++;
            $display("FAIL full_count got bytes=%0d dones=%0d want 32 1", n_bytes, n_done);
        end
        vectors++;
        if (done_cycle !== 96) begin
            errors++;
            $display("FAIL full_latency got %0d want 96", done_cycle);
        end
        vectors++;
        if (checksum !== 8'h66) begin
            errors++;
            $display("FAIL full_checksum got %h want 66", checksum);
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (checksum !== 8'h66 || busy !== 1'b0) begin
            errors++;
            $display("FAIL checksum_hold got ck=%h busy=%b want 66 0", checksum, busy);
        end
    endtask
    task automatic test_backpressure();
        load_base();
        run_dump(1, -1, -1);
        vectors++;
        if (rd_count[1] !== 1) begin
            errors++;
            $display("FAIL bp_single_read got %0d want 1", rd_count[1]);
        end
        vectors++;
        if (n_bytes !== 32 || done_cycle !== 106) begin
            errors++;
            $display("FAIL bp_timing got bytes=%0d done=%0d want 32 106", n_bytes, done_cycle);
        end
        vectors++;
        if (checksum !== 8'h66) begin
            errors++;
            $display("FAIL bp_checksum got %h want 66", checksum);
        end
    endtask
    task automatic test_start_ignored();
        int reads = 0;
        load_base();
        run_dump(0, 5, -1);
        for (int i = 0; i < 32; i++) reads += (rd_count[i] == 1) ? 1 : 0;
        vectors++;
        if (n_bytes !== 32 || n_done !== 1 || reads !== 32) begin
            errors++;
            $display("FAIL restart_ignored got bytes=%0d dones=%0d reads=%0d want 32 1 32", n_bytes, n_done, reads);
        end
        vectors++;
        if (done_cycle !== 96 || checksum !== 8'h66) begin
            errors++;
            $display("FAIL restart_result got done=%0d ck=%h want 96 66", done_cycle, checksum);
        end
    endtask
    task automatic test_reset_mid();
        load_base();
        run_dump(0, -1, 16);
        vectors++;
        if ({busy, done, bus.dump_valid, bus.dump_last, bus.mem_rd} !== 5'b0 || n_done !== 0) begin
            errors++;
            $display("FAIL abort_ctrl got %b dones=%0d want 00000 0", {busy, done, bus.dump_valid, bus.dump_last, bus.mem_rd}, n_done);
        end
        vectors++;
        if ({bus.mem_addr, bus.dump_addr, bus.dump_data, checksum} !== 26'b0) begin
            errors++;
            $display("FAIL abort_data got ma=%h da=%h dd=%h ck=%h want 0", bus.mem_addr, bus.dump_addr, bus.dump_data, checksum);
        end
        @(negedge clk);
        rst = 0;
        run_dump(0, -1, -1);
        vectors++;
        if (n_bytes !== 32 || done_cycle !== 96 || checksum !== 8'h66) begin
            errors++;
            $display("FAIL after_abort got bytes=%0d done=%0d ck=%h want 32 96 66", n_bytes, done_cycle, checksum);
        end
    endtask
    task automatic test_all_ff();
        for (int i = 0; i < 32; i++) mem[i] = 8'hFF;
        run_dump(0, -1, -1);
        vectors++;
        if (checksum !== 8'h00 || n_bytes !== 32) begin
            errors++;
            $display("FAIL all_ff got ck=%h bytes=%0d want 00 32", checksum, n_bytes);
        end
    endtask
    task automatic test_random();
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
            run_dump(2, -1, -1);
            vectors++;
            if (n_bytes !== 32 || n_done !== 1 || q.size() !== 0) begin
                errors++;
                $display("FAIL rand_count dump=%0d got bytes=%0d dones=%0d left=%0d want 32 1 0", k, n_bytes, n_done, q.size());
            end
            vectors++;
            if (checksum !== exp_checksum) begin
                errors++;
                $display("FAIL rand_checksum dump=%0d got %h want %h", k, checksum, exp_checksum);
            end
        end
    endtask
    initial begin
        test_reset();
        test_full_dump();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_all_ff();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
